// File: rtl/adc_seq_pkg.sv
// Shared types and constants for the ADC report sequencer.
// Frame format is selected in the top by ADC_SEQ_HEX_EN (hex when defined, binary otherwise).
package adc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_DV,
    ST_SEND,
    ST_WAIT_DONE
  } state_e;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_A    = 8'h41;

  localparam int unsigned BIN_DIGITS    = 12;
  localparam int unsigned BIN_FRAME_LEN = 14;
  localparam int unsigned HEX_DIGITS    = 3;
  localparam int unsigned HEX_FRAME_LEN = 5;

  // Binary frame: bit 11 first as '0'/'1', then LF, CR.
  function automatic logic [7:0] bin_char(input logic [11:0] s, input logic [3:0] idx);
    logic [7:0] c;
    if (idx < 4'(BIN_DIGITS)) begin
      c = ASCII_ZERO + {7'd0, s[4'd11 - idx]};
    end else if (idx == 4'(BIN_DIGITS)) begin
      c = ASCII_LF;
    end else begin
      c = ASCII_CR;
    end
    return c;
  endfunction

  // Hex frame: nibble 11:8 first as uppercase ASCII, then LF, CR.
  function automatic logic [7:0] hex_char(input logic [11:0] s, input logic [3:0] idx);
    logic [3:0] nib;
    logic [7:0] c;
    case (idx)
      4'd0:    nib = s[11:8];
      4'd1:    nib = s[7:4];
      default: nib = s[3:0];
    endcase
    if (idx < 4'(HEX_DIGITS)) begin
      c = (nib < 4'd10) ? (ASCII_ZERO + {4'd0, nib}) : (ASCII_A + {4'd0, nib} - 8'd10);
    end else if (idx == 4'(HEX_DIGITS)) begin
      c = ASCII_LF;
    end else begin
      c = ASCII_CR;
    end
    return c;
  endfunction

endpackage

// File: rtl/adc_report_sequencer_tick_gen.sv
// Free-running sample-period counter; o_tick is high while the count sits at SAMPLE_PERIOD-1.
module adc_seq_tick_gen
  import adc_seq_pkg::*;
#(
  parameter int unsigned SAMPLE_PERIOD = 100000000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);

  localparam int unsigned CW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          at_end;

  // Wrap the counter at the end of each period and flag the last count.
  always_comb begin
    at_end = (cnt_q == CW'(SAMPLE_PERIOD - 1));
    cnt_d  = at_end ? '0 : cnt_q + CW'(1);
    o_tick = at_end;
  end

  // Period counter register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/adc_report_sequencer.sv
// Periodic ADC conversion and ASCII report over a byte-wide UART handshake.
// Define ADC_SEQ_HEX_EN for a 3-digit hex frame; default is a 12-digit binary frame.
module adc_report_sequencer
  import adc_seq_pkg::*;
#(
  parameter int unsigned SAMPLE_PERIOD = 100000000,
  parameter logic [5:0]  ADC_CFG_BITS  = 6'b100000,
  parameter int unsigned ADC_TIMEOUT   = 4096
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  output logic        o_request_conversion,
  output logic [5:0]  o_adc_tx_bits,
  input  logic        i_conv_in_process,
  input  logic        i_adc_dv,
  input  logic [11:0] i_adc_data,
  output logic [7:0]  o_byte_to_send,
  output logic        o_data_valid,
  input  logic        i_good_to_reset_dv,
  input  logic        i_send_complete,
  output logic        o_overrun,
  output logic        o_adc_timeout
);

  localparam int unsigned TW = (ADC_TIMEOUT > 1) ? $clog2(ADC_TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(ADC_TIMEOUT - 1);
`ifdef ADC_SEQ_HEX_EN
  localparam logic [3:0] LAST_IDX = 4'(HEX_FRAME_LEN - 1);
`else
  localparam logic [3:0] LAST_IDX = 4'(BIN_FRAME_LEN - 1);
`endif

  function automatic logic [7:0] frame_char(input logic [11:0] s, input logic [3:0] idx);
`ifdef ADC_SEQ_HEX_EN
    return hex_char(s, idx);
`else
    return bin_char(s, idx);
`endif
  endfunction

  state_e        state_q, state_d;
  logic          req_q, req_d;
  logic          dv_q, dv_d;
  logic [7:0]    byte_q, byte_d;
  logic [3:0]    idx_q, idx_d;
  logic [11:0]   sample_q, sample_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          overrun_q, overrun_d;
  logic          timeout_q, timeout_d;
  logic          tick;

  adc_seq_tick_gen #(.SAMPLE_PERIOD(SAMPLE_PERIOD)) u_tick_gen (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .o_tick  (tick)
  );

  assign o_request_conversion = req_q;
  assign o_adc_tx_bits        = ADC_CFG_BITS;
  assign o_byte_to_send       = byte_q;
  assign o_data_valid         = dv_q;
  assign o_overrun            = overrun_q;
  assign o_adc_timeout        = timeout_q;

  // Next-state and registered-output logic; the next byte is loaded only when valid is (re)raised.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    dv_d      = dv_q;
    byte_d    = byte_q;
    idx_d     = idx_q;
    sample_d  = sample_q;
    to_cnt_d  = to_cnt_q;
    overrun_d = 1'b0;
    timeout_d = 1'b0;

    if (tick && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (tick && i_enable) begin
          state_d  = ST_REQ;
          req_d    = 1'b1;
          to_cnt_d = '0;
        end
      end
      ST_REQ: begin
        to_cnt_d = to_cnt_q + TW'(1);
        if (to_cnt_q == TO_LAST) begin
          timeout_d = 1'b1;
          req_d     = 1'b0;
          state_d   = ST_IDLE;
        end else if (i_conv_in_process) begin
          req_d   = 1'b0;
          state_d = ST_WAIT_DV;
        end
      end
      ST_WAIT_DV: begin
        to_cnt_d = to_cnt_q + TW'(1);
        if (i_adc_dv) begin
          sample_d = i_adc_data;
          idx_d    = '0;
          byte_d   = frame_char(i_adc_data, 4'd0);
          dv_d     = 1'b1;
          state_d  = ST_SEND;
        end else if (to_cnt_q == TO_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (i_good_to_reset_dv) begin
          dv_d    = 1'b0;
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (i_send_complete) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + 4'd1;
            byte_d  = frame_char(sample_q, idx_q + 4'd1);
            dv_d    = 1'b1;
            state_d = ST_SEND;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      req_q     <= 1'b0;
      dv_q      <= 1'b0;
      byte_q    <= 8'h00;
      idx_q     <= '0;
      sample_q  <= '0;
      to_cnt_q  <= '0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      dv_q      <= dv_d;
      byte_q    <= byte_d;
      idx_q     <= idx_d;
      sample_q  <= sample_d;
      to_cnt_q  <= to_cnt_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

endmodule

// File: tb/tb_adc_report_sequencer.sv
// Scoreboard bench for adc_report_sequencer with ADC and UART models.
module tb_adc_report_sequencer;

  localparam int SP = 200;
  localparam int TO = 50;
`ifdef ADC_SEQ_HEX_EN
  localparam int          FLEN  = 5;
  localparam logic [11:0] FIXED = 12'h9F0;
`else
  localparam int          FLEN  = 14;
  localparam logic [11:0] FIXED = 12'hAB3;
`endif

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        req;
  logic [5:0]  tx_bits;
  logic        conv;
  logic        adc_dv;
  logic [11:0] adc_data;
  logic [7:0]  byte_out;
  logic        data_valid;
  logic        good;
  logic        cmpl;
  logic        overrun;
  logic        adc_to;

  adc_report_sequencer #(
    .SAMPLE_PERIOD (SP),
    .ADC_TIMEOUT   (TO)
  ) dut (
    .i_clk                (clk),
    .i_rst_n              (rst_n),
    .i_enable             (enable),
    .o_request_conversion (req),
    .o_adc_tx_bits        (tx_bits),
    .i_conv_in_process    (conv),
    .i_adc_dv             (adc_dv),
    .i_adc_data           (adc_data),
    .o_byte_to_send       (byte_out),
    .o_data_valid         (data_valid),
    .i_good_to_reset_dv   (good),
    .i_send_complete      (cmpl),
    .o_overrun            (overrun),
    .o_adc_timeout        (adc_to)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard of expected UART bytes, filled when the ADC model returns a sample.
  logic [7:0] exp_q[$];

  function automatic void push_frame(input logic [11:0] d);
    string s;
`ifdef ADC_SEQ_HEX_EN
    s = $sformatf("%h", d);
    s = s.toupper();
`else
    s = $sformatf("%b", d);
`endif
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h0A);
    exp_q.push_back(8'h0D);
  endfunction

  // Stimulus controls
  logic [11:0] adc_next = '0;
  bit          adc_silent = 0;
  bit          uart_slow = 0;
  int          uart_cnt = 0;

  // Reference model: period tick and a busy window from conversion start to frame end/timeout.
  int cyc = 0, pc = 0, req_edge = 0, frames_done = 0, ovr_exp_cnt = 0;
  bit busy = 0, conv_silent = 0, exp_ovr = 0, exp_to = 0, exp_req = 0;
  bit tick_now, was_busy;

  always @(posedge clk) begin
    cyc++;
    exp_ovr = 0; exp_to = 0; exp_req = 0;
    if (!rst_n) begin
      pc = 0; busy = 0;
    end else begin
      tick_now = (pc == SP - 1);
      pc = (pc + 1) % SP;
      was_busy = busy;
      if (tick_now) begin
        if (was_busy) begin
          exp_ovr = 1; ovr_exp_cnt++;
        end else if (enable) begin
          busy = 1; exp_req = 1; req_edge = cyc; conv_silent = adc_silent;
        end
      end
      if (was_busy) begin
        if (conv_silent && cyc == req_edge + TO) begin
          exp_to = 1; busy = 0;
        end else if (!conv_silent && cmpl && uart_cnt == FLEN) begin
          busy = 0; frames_done++;
        end
      end
    end
  end

  // ADC receiver model
  int a_st = 0, a_dly = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      a_st = 0; conv = 0; adc_dv = 0;
    end else begin
      case (a_st)
        0: begin
          adc_dv = 0; adc_data = 12'($urandom);
          if (req) begin a_dly = $urandom_range(0, 3); a_st = 1; end
        end
        1: if (a_dly == 0) begin conv = 1; a_dly = $urandom_range(1, 5); a_st = 2; end
           else a_dly--;
        2: if (a_dly == 0) begin
             conv = 0;
             if (!conv_silent) begin adc_dv = 1; adc_data = adc_next; push_frame(adc_next); end
             a_st = 3;
           end else a_dly--;
        default: begin adc_dv = 0; adc_data = 12'($urandom); a_st = 0; end
      endcase
    end
  end

  // UART transmitter model
  int u_st = 0, u_dly = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      u_st = 0; good = 0; cmpl = 0; uart_cnt = 0;
    end else begin
      case (u_st)
        0: begin
          if (cmpl && uart_cnt == FLEN) uart_cnt = 0;
          cmpl = 0;
          if (data_valid) begin
            u_dly = uart_slow ? $urandom_range(45, 55) : $urandom_range(0, 3);
            u_st = 1;
          end
        end
        1: if (u_dly == 0) begin good = 1; uart_cnt++; u_st = 2; end
           else u_dly--;
        2: begin
          good = 0;
          u_dly = uart_slow ? $urandom_range(45, 55) : $urandom_range(0, 3);
          u_st = 3;
        end
        default: if (u_dly == 0) begin cmpl = 1; u_st = 0; end
                 else u_dly--;
      endcase
    end
  end

  // Monitor: compares DUT activity against the scoreboard and model pulses.
  int  hs_cnt = 0, req_rises = 0, ovr_seen = 0, to_seen = 0;
  bit  req_prev = 0, dv_prev = 0, req_rise;
  logic [7:0] vbyte = '0;
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      req_rise = req && !req_prev;
      if (req_rise || exp_req) chk("request_start", req_rise, exp_req);
      if (req_rise) req_rises++;
      if (overrun || exp_ovr) chk("overrun_pulse", overrun, exp_ovr);
      if (overrun) ovr_seen++;
      if (adc_to || exp_to) chk("adc_timeout_pulse", adc_to, exp_to);
      if (adc_to) to_seen++;
      if (data_valid && !dv_prev) vbyte = byte_out;
      if (data_valid && good) begin
        hs_cnt++;
        chk("byte_stable_while_valid", byte_out, vbyte);
        chk("byte_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("uart_byte", byte_out, exp_q.pop_front());
      end
      req_prev = req; dv_prev = data_valid;
    end else begin
      req_prev = 0; dv_prev = 0;
    end
  end

  task automatic wait_frames(input int n, input int budget, input string name);
    int target;
    int k;
    target = frames_done + n;
    k = 0;
    while (frames_done < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, frames_done >= target, 1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int hb, ob, rb, tb0, k;

  initial begin
    rst_n = 0; enable = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_request", req, 0);
    chk("reset_valid", data_valid, 0);
    chk("reset_byte", byte_out, 8'h00);
    chk("reset_overrun", overrun, 0);
    chk("reset_timeout", adc_to, 0);
    chk("cfg_bits", tx_bits, 6'b100000);
    @(negedge clk);
    rst_n = 1;

    // Fixed sample frame
    adc_next = FIXED; enable = 1; hb = hs_cnt;
    wait_frames(1, 1500, "fixed_frame_done");
    chk("fixed_frame_handshakes", hs_cnt - hb, FLEN);

    // Random samples
    for (int i = 0; i < 4; i++) begin
      adc_next = 12'($urandom); hb = hs_cnt;
      wait_frames(1, 1500, "random_frame_done");
      chk("random_frame_handshakes", hs_cnt - hb, FLEN);
    end

    // ADC never returns data
    adc_silent = 1; tb0 = to_seen; hb = hs_cnt; k = 0;
    while (to_seen == tb0 && k < 400) begin @(negedge clk); k++; end
    chk("timeout_seen", to_seen - tb0, 1);
    chk("timeout_no_uart", hs_cnt - hb, 0);
    adc_silent = 0; adc_next = 12'($urandom);
    wait_frames(1, 1500, "retry_frame_done");
    chk("retry_frame_handshakes", hs_cnt - hb, FLEN);
    chk("single_timeout", to_seen - tb0, 1);

    // Slow UART: ticks during the frame must overrun
    uart_slow = 1; ob = ovr_seen; adc_next = 12'($urandom); hb = hs_cnt;
    wait_frames(1, 4000, "slow_frame_done");
    chk("slow_frame_handshakes", hs_cnt - hb, FLEN);
    chk("slow_overruns_ge2", (ovr_seen - ob) >= 2, 1);
    uart_slow = 0;

    // Disable mid-frame, stay disabled for 3 ticks, then re-enable
    rb = req_rises; k = 0; adc_next = 12'($urandom); hb = hs_cnt;
    while (req_rises == rb && k < 400) begin @(negedge clk); k++; end
    chk("request_before_disable", req_rises - rb, 1);
    enable = 0;
    wait_frames(1, 1500, "frame_survives_disable");
    chk("disabled_frame_handshakes", hs_cnt - hb, FLEN);
    rb = req_rises; ob = ovr_seen;
    repeat (3 * SP) @(negedge clk);
    chk("disabled_no_request", req_rises - rb, 0);
    chk("disabled_no_overrun", ovr_seen - ob, 0);
    enable = 1; adc_next = 12'($urandom);
    wait_frames(1, 1500, "reenabled_frame_done");

    // Reset during byte 5
    adc_next = 12'($urandom); hb = hs_cnt; k = 0;
    while (!(hs_cnt - hb >= 5 && data_valid) && k < 1500) begin
      @(negedge clk); #2; k++;
    end
    chk("reached_byte5", (hs_cnt - hb == 5) && data_valid, 1);
    rst_n = 0;
    #1;
    chk("midreset_valid", data_valid, 0);
    chk("midreset_byte", byte_out, 8'h00);
    chk("midreset_request", req, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1;
    adc_next = 12'($urandom); hb = hs_cnt;
    wait_frames(1, 1500, "post_reset_frame_done");
    chk("post_reset_handshakes", hs_cnt - hb, FLEN);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
